// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder that sums two WIDTH-bit operands CHUNK bits per clock with a registered inter-chunk carry.
// Define CHUNKED_SERIAL_ADDER_SUB_EN to add the sub_i port and A - B - c_i subtraction.
module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             ov_o
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IW    = $clog2(WIDTH);

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_paramCheck
        $error("chunked_serial_adder: WIDTH must be >= 2 and an exact multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_ov;

    logic [WIDTH-1:0] w_bIn;
    logic             w_cIn;
    logic             w_invOut;
    logic [IW-1:0]    w_base;
    logic [CHUNK-1:0] w_aChunk;
    logic [CHUNK-1:0] w_bChunk;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_ov;
    logic             w_last;

    // Subtraction is folded into the capture: B and the borrow-in are stored inverted,
    // so the chunk datapath is always a plain adder and only the final carry is flipped.
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    logic r_sub;
    assign w_bIn    = sub_i ? ~b_i : b_i;
    assign w_cIn    = sub_i ^ c_i;
    assign w_invOut = r_sub;
`else
    assign w_bIn    = b_i;
    assign w_cIn    = c_i;
    assign w_invOut = 1'b0;
`endif

    assign w_base   = IW'(32'(r_cnt) * CHUNK);
    assign w_aChunk = r_a[w_base +: CHUNK];
    assign w_bChunk = r_b[w_base +: CHUNK];
    assign w_sum    = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};
    assign w_last   = (r_cnt == CW'(STEPS - 1));

    always_comb begin
        w_result = r_work;
        w_result[w_base +: CHUNK] = w_sum[CHUNK-1:0];
    end

    // Same-sign operands producing an opposite-sign result equals carry-in XOR carry-out at the MSB.
    assign w_ov = (r_a[WIDTH-1] ~^ r_b[WIDTH-1]) & (w_result[WIDTH-1] ^ r_a[WIDTH-1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_work  <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_ov    <= 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_a     <= a_i;
                        r_b     <= w_bIn;
                        r_carry <= w_cIn;
                        r_cnt   <= '0;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
                        r_sub   <= sub_i;
`endif
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_work  <= w_result;
                    r_carry <= w_sum[CHUNK];
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_s     <= w_result;
                        r_c     <= w_sum[CHUNK] ^ w_invOut;
                        r_ov    <= w_ov;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o = (r_state == IDLE);
    assign valid_o = (r_state == DONE);
    assign s_o     = r_s;
    assign c_o     = r_c;
    assign ov_o    = r_ov;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench: four adders (CHUNK = 1, 2, 4, 8) share one stimulus stream and are checked
// against an arithmetic reference model; acceptance pushes expectations, a monitor pops them.
module tb_chunked_serial_adder;

    localparam int W  = 8;
    localparam int NI = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         validI;
    logic         readyI;
    logic [W-1:0] aI;
    logic [W-1:0] bI;
    logic         cI;
    logic         subI;

    logic         readyO [NI];
    logic         validO [NI];
    logic [W-1:0] sO     [NI];
    logic         cO     [NI];
    logic         ovO    [NI];

    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    int           accCount [NI];
    logic [9:0]   expQ [NI][$];
    int           accQ [NI][$];
    logic         prevValid [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        chunked_serial_adder #(.WIDTH(W), .CHUNK(1 << g)) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .valid_i (validI),
            .ready_o (readyO[g]),
            .a_i     (aI),
            .b_i     (bI),
            .c_i     (cI),
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
            .sub_i   (subI),
`endif
            .valid_o (validO[g]),
            .ready_i (readyI),
            .s_o     (sO[g]),
            .c_o     (cO[g]),
            .ov_o    (ovO[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic; result packed as {ov, carry/borrow, sum}.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic c, input logic sub);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int cc = int'(c);
        int ru;
        int rs;
        logic co;
        logic ov;
        if (!sub) begin
            ru = ua + ub + cc;
            rs = sa + sb + cc;
            co = (ru > 255);
        end else begin
            ru = ua - ub - cc;
            rs = sa - sb - cc;
            co = (ru < 0);
        end
        ov = (rs > 127) || (rs < -128);
        return {ov, co, ru[7:0]};
    endfunction

    // Monitor: samples on the falling edge, i.e. the values the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < NI; k++) begin
                expQ[k].delete();
                accQ[k].delete();
                prevValid[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (validO[k] && !prevValid[k]) begin
                    if (accQ[k].size() == 0)
                        check($sformatf("unexpected valid_o chunk%0d", 1 << k), 1, 0);
                    else
                        check($sformatf("latency chunk%0d", 1 << k),
                              cyc - accQ[k].pop_front() - 1, W >> k);
                end
                if (validO[k])
                    check($sformatf("ready_o low in DONE chunk%0d", 1 << k), readyO[k], 0);
                if (validO[k] && readyI) begin
                    if (expQ[k].size() == 0)
                        check($sformatf("result without op chunk%0d", 1 << k), 1, 0);
                    else
                        check($sformatf("result {ov,c,s} chunk%0d", 1 << k),
                              {ovO[k], cO[k], sO[k]}, expQ[k].pop_front());
                end
                if (validI && readyO[k]) begin
                    expQ[k].push_back(model(aI, bI, cI, subI));
                    accQ[k].push_back(cyc);
                    accCount[k]++;
                end
                prevValid[k] = validO[k];
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input logic sub);
        bit allReady = 1'b0;
        for (int n = 0; n < 50 && !allReady; n++) begin
            @(posedge clk); #1;
            allReady = 1'b1;
            for (int k = 0; k < NI; k++) allReady &= readyO[k];
        end
        check("all ready before stimulus", allReady, 1);
        validI = 1'b1; aI = a; bI = b; cI = c; subI = sub;
        @(posedge clk); #1;
        validI = 1'b0;
    endtask

    task automatic waitAllValid();
        bit allValid = 1'b0;
        for (int n = 0; n < 20 && !allValid; n++) begin
            allValid = 1'b1;
            for (int k = 0; k < NI; k++) allValid &= validO[k];
            if (!allValid) begin
                @(posedge clk); #1;
            end
        end
        check("all valid_o within bound", allValid, 1);
    endtask

    task automatic checkOutput(input string name, input logic [7:0] s, input logic c, input logic ov);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s s_o chunk%0d", name, 1 << k), sO[k], s);
            check($sformatf("%s c_o chunk%0d", name, 1 << k), cO[k], c);
            check($sformatf("%s ov_o chunk%0d", name, 1 << k), ovO[k], ov);
        end
    endtask

    task automatic checkReset(input string name);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s ready_o chunk%0d", name, 1 << k), readyO[k], 1);
            check($sformatf("%s valid_o chunk%0d", name, 1 << k), validO[k], 0);
        end
        checkOutput(name, 8'h00, 1'b0, 1'b0);
    endtask

    // Run one directed op, hold the results under backpressure, check them, then release.
    task automatic directedOp(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic c, input logic sub,
                              input logic [7:0] s, input logic co, input logic ov);
        readyI = 1'b0;
        applyStimulus(a, b, c, sub);
        waitAllValid();
        checkOutput(name, s, co, ov);
        readyI = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; validI = 1'b0; readyI = 1'b1;
        aI = '0; bI = '0; cI = 1'b0; subI = 1'b0;
        for (int k = 0; k < NI; k++) accCount[k] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkReset("after reset");

        directedOp("7F+01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // Backpressure: results held, ready_o low, operand pulses ignored.
        readyI = 1'b0;
        applyStimulus(8'hFF, 8'h01, 1'b1, 1'b0);
        waitAllValid();
        for (int n = 0; n < 5; n++) begin
            validI = 1'b1; aI = 8'h11; bI = 8'h11; cI = 1'b0;
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++)
                check($sformatf("held valid_o chunk%0d", 1 << k), validO[k], 1);
            checkOutput("FF+01+1 held", 8'h01, 1'b1, 1'b0);
        end
        validI = 1'b0;
        readyI = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("idle after release ready_o chunk%0d", 1 << k), readyO[k], 1);
            check($sformatf("idle after release valid_o chunk%0d", 1 << k), validO[k], 0);
        end

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
        directedOp("05-07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
        directedOp("80-01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1);
`endif

        // Reset while the CHUNK=1 instance is mid-RUN: the aborted op must never complete.
        applyStimulus(8'h3C, 8'h5A, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkReset("after mid-run reset");
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NI; k++)
                check($sformatf("no valid_o after abort chunk%0d", 1 << k), validO[k], 0);
        end

        // Random traffic: operands and valid_i change every cycle regardless of ready_o.
        accCount[0] = 0;
        for (int n = 0; n < 60000 && accCount[0] < 1000; n++) begin
            @(posedge clk); #1;
            validI = ($urandom_range(0, 3) != 0);
            aI     = 8'($urandom);
            bI     = 8'($urandom);
            cI     = 1'($urandom);
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
            subI   = 1'($urandom);
`endif
            readyI = ($urandom_range(0, 2) != 0);
        end
        check("random ops accepted by chunk1", accCount[0] >= 1000, 1);
        validI = 1'b0;
        readyI = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++)
            check($sformatf("no pending results chunk%0d", 1 << k), expQ[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation timed out at cycle %0d", cyc);
        $fatal(1, "[TB] timeout");
    end

endmodule
